// File: rtl/mips_pkg.sv
// Shared MIPS EX-stage definitions: ALUCtrl code map, MDU state encoding and default width.
package mips_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic [4:0] ALU_AND  = 5'b00000;
  localparam logic [4:0] ALU_OR   = 5'b00001;
  localparam logic [4:0] ALU_ADD  = 5'b00010;
  localparam logic [4:0] ALU_SUB  = 5'b00110;
  localparam logic [4:0] ALU_SLT  = 5'b00111;
  localparam logic [4:0] ALU_NOR  = 5'b01100;
  localparam logic [4:0] ALU_XOR  = 5'b01101;
  localparam logic [4:0] ALU_SLL  = 5'b10000;
  localparam logic [4:0] ALU_SRL  = 5'b10001;
  localparam logic [4:0] ALU_SRA  = 5'b10010;
  localparam logic [4:0] ALU_LUI  = 5'b10011;

  localparam logic [4:0] ALU_MULT = 5'b11000;
  localparam logic [4:0] ALU_DIV  = 5'b11001;
  localparam logic [4:0] ALU_MFHI = 5'b11010;
  localparam logic [4:0] ALU_MFLO = 5'b11011;
  localparam logic [4:0] ALU_MTHI = 5'b11100;
  localparam logic [4:0] ALU_MTLO = 5'b11101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_e;

  function automatic logic is_mdu_code(input logic [4:0] code);
    return (code[4:3] == 2'b11) && (code[2:0] <= 3'b101);
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// One iteration of the MDU datapath: shift-add multiply step or restoring divide step.
module mdu_iter_core
  import mips_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH-1:0]     opnd_i,
  output logic [2*WIDTH-1:0]   acc_o
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_top;
  logic [WIDTH+1:0] div_diff;

  // MUL: acc = {partial product, remaining multiplier bits}; DIV: acc = {remainder, dividend/quotient}
  always_comb begin
    mul_sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
    div_top  = acc_i[2*WIDTH-2:WIDTH-1];
    div_diff = {1'b0, div_top} - {2'b00, opnd_i};
    if (is_div) begin
      if (div_diff[WIDTH+1]) begin
        acc_o = {acc_i[2*WIDTH-2:0], 1'b0};
      end else begin
        acc_o = {div_diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_o = {mul_sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Sequential MIPS multiply/divide unit with HI/LO registers and busy/stall handshake.
// Define MDU_FAST_MUL_EN to compute mult in a single cycle instead of iterating.
module mdu_seq
  import mips_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       ALUCtrl,
  input  logic             Sign,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};

  mdu_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               op_div_q, op_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  mdu_iter_core #(.WIDTH(WIDTH)) u_iter (
    .is_div (state_q == ST_DIV),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (acc_step)
  );

  // Operand magnitudes at accept and sign restoration of the finished result
  always_comb begin
    a_neg    = Sign & in1[WIDTH-1];
    b_neg    = Sign & in2[WIDTH-1];
    mag_a    = a_neg ? (~in1 + ONE_W) : in1;
    mag_b    = b_neg ? (~in2 + ONE_W) : in2;
    prod_fix = neg_res_q ? (~acc_q + ONE_2W) : acc_q;
    quot_fix = neg_res_q ? (~acc_q[WIDTH-1:0] + ONE_W) : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + ONE_W) : acc_q[2*WIDTH-1:WIDTH];
  end

  // FSM and HI/LO next-state
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    op_div_d  = op_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (ALUCtrl)
            ALU_MULT: begin
              op_div_d  = 1'b0;
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = 1'b0;
              div0_d    = 1'b0;
              cnt_d     = {CW{1'b0}};
`ifdef MDU_FAST_MUL_EN
              acc_d     = {ZERO_W, mag_a} * {ZERO_W, mag_b};
              state_d   = ST_FIX;
`else
              acc_d     = {ZERO_W, mag_b};
              opnd_d    = mag_a;
              state_d   = ST_MUL;
`endif
            end
            ALU_DIV: begin
              op_div_d  = 1'b1;
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              div0_d    = (in2 == ZERO_W);
              cnt_d     = {CW{1'b0}};
              acc_d     = {ZERO_W, mag_a};
              opnd_d    = mag_b;
              state_d   = ST_DIV;
            end
            ALU_MTHI: hi_d = in1;
            ALU_MTLO: lo_d = in1;
            default:  state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FIX;
        end else begin
          state_d = state_q;
        end
      end
      ST_FIX: begin
        // Divide-by-zero: remainder path already reproduces the raw dividend in HI
        if (op_div_q) begin
          hi_d = rem_fix;
          lo_d = div0_q ? {WIDTH{1'b1}} : quot_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and architectural registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {CW{1'b0}};
      acc_q     <= {(2*WIDTH){1'b0}};
      opnd_q    <= ZERO_W;
      op_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= ZERO_W;
      lo_q      <= ZERO_W;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      op_div_q  <= op_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  // mfhi/mflo read-out and handshake
  always_comb begin
    case (ALUCtrl)
      ALU_MFHI: out = hi_q;
      ALU_MFLO: out = lo_q;
      default:  out = ZERO_W;
    endcase
    busy  = (state_q != ST_IDLE);
    stall = start & is_mdu_code(ALUCtrl) & busy;
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed vector table, multi-cycle corner sequences, random ops vs. arithmetic model.
module tb_mdu_seq;
  import mips_pkg::*;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        reset, start, Sign;
  logic [4:0]  ALUCtrl;
  logic [31:0] in1, in2, out, hi, lo;
  logic        busy, stall, done;

  int checks = 0;
  int errors = 0;

  mdu_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .ALUCtrl(ALUCtrl), .Sign(Sign),
    .in1(in1), .in2(in2), .out(out), .busy(busy), .stall(stall), .done(done),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, returns {HI, LO}
  function automatic logic [63:0] model(input logic is_div, input logic sgn,
                                        input logic [31:0] a, input logic [31:0] b);
    longint    sa, sb;
    logic [63:0] p, q, r;
    sa = sgn ? longint'($signed(a)) : longint'({32'h0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'h0, b});
    if (!is_div) begin
      if (sgn) p = sa * sb;
      else     p = {32'h0, a} * {32'h0, b};
      return p;
    end
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic issue(input logic [4:0] op, input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; ALUCtrl = op; Sign = sgn; in1 = a; in2 = b;
    @(posedge clk); #1;
    start = 1'b0; ALUCtrl = ALU_ADD;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic do_op(input string name, input logic [4:0] op, input logic sgn,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic pulse_chk);
    int lat;
    issue(op, sgn, a, b);
    chk({name, ".busy"}, {63'h0, busy}, 64'h1);
    wait_done(lat);
    chk({name, ".lat"}, 64'(lat), (op == ALU_DIV) ? 64'(DIV_LAT) : 64'(MUL_LAT));
    chk({name, ".hi"}, {32'h0, hi}, {32'h0, ehi});
    chk({name, ".lo"}, {32'h0, lo}, {32'h0, elo});
    chk({name, ".busy_end"}, {63'h0, busy}, 64'h0);
    if (pulse_chk) begin
      @(posedge clk); #1;
      chk({name, ".done_pulse"}, {63'h0, done}, 64'h0);
    end
  endtask

  initial begin
    logic [63:0] m;
    logic [31:0] ra, rb, prev_lo;
    logic        rdiv, rsgn;
    int          lat;
    bit          saw_done;

    vecs[0] = '{ALU_MULT, 1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1] = '{ALU_MULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{ALU_DIV,  1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{ALU_DIV,  1'b1, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF};
    vecs[4] = '{ALU_DIV,  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{ALU_DIV,  1'b0, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
    vecs[6] = '{ALU_MULT, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[7] = '{ALU_DIV,  1'b0, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[8] = '{ALU_DIV,  1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[9] = '{ALU_MULT, 1'b1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};

    reset = 1'b1; start = 1'b0; ALUCtrl = ALU_ADD; Sign = 1'b0; in1 = 32'h0; in2 = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.hi",   {32'h0, hi}, 64'h0);
    chk("rst.lo",   {32'h0, lo}, 64'h0);
    chk("rst.busy", {63'h0, busy}, 64'h0);
    chk("rst.done", {63'h0, done}, 64'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b,
            vecs[i].exp_hi, vecs[i].exp_lo, 1'b1);
    end
    prev_lo = vecs[9].exp_lo;

    // Idle read-out: no stall, out follows HI; non-MDU code reads 0
    @(negedge clk);
    start = 1'b1; ALUCtrl = ALU_MFHI; #1;
    chk("idle.stall", {63'h0, stall}, 64'h0);
    chk("idle.mfhi", {32'h0, out}, {32'h0, vecs[9].exp_hi});
    ALUCtrl = ALU_ADD; #1;
    chk("idle.out_alu", {32'h0, out}, 64'h0);
    start = 1'b0;

    // mflo and mtlo while busy: stall, old LO visible, write ignored
    issue(ALU_DIV, 1'b0, 32'd100, 32'd7);
    @(negedge clk);
    start = 1'b1; ALUCtrl = ALU_MFLO; #1;
    chk("busy.stall", {63'h0, stall}, 64'h1);
    chk("busy.mflo", {32'h0, out}, {32'h0, prev_lo});
    ALUCtrl = ALU_MTLO; in1 = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk("busy.mtlo_ign", {32'h0, lo}, {32'h0, prev_lo});
    start = 1'b0; ALUCtrl = ALU_ADD;
    wait_done(lat);
    chk("busy.seen_done", {63'h0, (lat > 0)}, 64'h1);
    chk("busy.div_lo", {32'h0, lo}, 64'd14);
    chk("busy.div_hi", {32'h0, hi}, 64'd2);

    // Reset at iteration 10 aborts the operation
    issue(ALU_MULT, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort.busy", {63'h0, busy}, 64'h0);
    chk("abort.hi", {32'h0, hi}, 64'h0);
    chk("abort.lo", {32'h0, lo}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    chk("abort.quiet", {63'h0, saw_done}, 64'h0);
    issue(ALU_MTHI, 1'b0, 32'h0000_1234, 32'h0);
    chk("mthi.hi", {32'h0, hi}, 64'h1234);
    chk("mthi.busy", {63'h0, busy}, 64'h0);
    issue(ALU_MTLO, 1'b0, 32'hCAFE_0001, 32'h0);
    chk("mtlo.lo", {32'h0, lo}, 64'hCAFE_0001);
    chk("mtlo.hi_kept", {32'h0, hi}, 64'h1234);

    // Random back-to-back operations against the arithmetic model
    for (int n = 0; n < 40; n++) begin
      rdiv = 1'($urandom_range(0, 1));
      rsgn = 1'($urandom_range(0, 1));
      ra   = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(0, 5));
        1:       rb = 32'hFFFF_FFFF;
        default: rb = 32'($urandom);
      endcase
      m = model(rdiv, rsgn, ra, rb);
      do_op($sformatf("rnd%0d", n), rdiv ? ALU_DIV : ALU_MULT, rsgn, ra, rb,
            m[63:32], m[31:0], 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
# mdu_seq

Sequential multiply/divide unit in the EX stage, alongside the ALU, consuming the same 5-bit `ALUCtrl` and `Sign` produced by ALU control. It executes MIPS `mult/multu/div/divu` iteratively into architectural HI/LO registers, and serves `mfhi/mflo/mthi/mtlo`. A busy/stall handshake lets the core freeze while an operation is in flight.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: a valid MDU instruction is in EX this cycle.
- `ALUCtrl`  in  5: operation code; MDU codes are listed below, all others are ignored.
- `Sign`  in  1: 1 = signed (`mult`, `div`), 0 = unsigned (`multu`, `divu`).
- `in1`  in  WIDTH: rs operand (multiplicand/dividend; source for `mthi`/`mtlo`).
- `in2`  in  WIDTH: rt operand (multiplier/divisor).
- `out`  out  WIDTH: HI for `mfhi`, LO for `mflo`, else 0; combinational.
- `busy`  out  1: iterative operation in progress.
- `stall`  out  1: `start` & MDU code & `busy`; the core must hold EX.
- `done`  out  1: one-cycle pulse when HI/LO take a mult/div result.
- `hi`, `lo`  out  WIDTH each: architectural registers.

## Operation
- MDU `ALUCtrl` codes: `11000` mult, `11001` div, `11010` mfhi, `11011` mflo, `11100` mthi, `11101` mtlo.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE → MUL on `start` & mult.
  - IDLE → DIV on `start` & div.
  - MUL/DIV → FIX after exactly WIDTH iteration cycles.
  - FIX → IDLE.
- Accepting an operation:
  - The operation is accepted only in IDLE.
  - On accept, latch |in1| and |in2| (magnitudes when `Sign`=1, raw values otherwise) plus the result signs.
  - Clear the counter.
- MUL: shift-add, one multiplier bit per cycle, 2·WIDTH-bit accumulator.
- DIV: restoring division, one quotient bit per cycle.
- FIX: negate the product/quotient/remainder as the signs require, then write HI/LO.
  - mult: HI = product[63:32], LO = product[31:0].
  - div: LO = quotient, truncated toward zero; HI = remainder, with the sign of the dividend.
- Divide by zero: LO = all ones, HI = dividend (raw `in1`). No trap.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- `mthi`/`mtlo` in IDLE with `start`: write `in1` to HI/LO at that edge.
- Any MDU code with `start` while busy: ignored, `stall`=1; the core re-presents it.
- `mfhi`/`mflo` while busy: `out` still shows the old HI/LO, `stall`=1.
- Reset, including mid-operation: state = IDLE; hi = lo = 0; busy = done = 0; counter = 0; the in-flight operation is aborted.

## Timing
- Accept edge E0.
- `busy`=1 from after E0 through the FIX cycle.
- Iterations occur at E1..E32 (WIDTH=32).
- FIX writes HI/LO at E33; `done`=1 during the cycle after E33; `busy`=0 after E33.
- A new operation can be accepted at E34, the cycle in which `done` is high.
- Latency: 33 cycles accept-to-result for iterative operations.
- `mthi`/`mtlo` take 1 cycle; `mfhi`/`mflo` are 0 cycles (combinational).

## Configuration
- `MDU_FAST_MUL_EN` defined: mult skips MUL.
  - IDLE → FIX with a single-cycle WIDTH×WIDTH product.
  - `busy` is high for 1 cycle; HI/LO are written at E1; `done` is high after E1.
- Undefined: 33-cycle iterative multiply as above.
- Division is iterative in both cases.

## Structure
- Shared package `mips_pkg`:
  - All `ALUCtrl` code constants: existing ALU codes plus the MDU codes above.
  - FSM state enum.
  - `WIDTH` default.
- Sub-module `mdu_iter_core`: combinational per-cycle step that returns the next accumulator/remainder/quotient for MUL or DIV.
- `mdu_seq` holds the FSM, registers, sign fix-up and output mux.

## Test plan
- signed mult 0xFFFFFFFE × 3 → after 33 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFA, `done` one pulse.
- multu 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- signed div −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div by zero: 5 / 0 → LO=0xFFFFFFFF, HI=5.
- Signed overflow: 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- `mflo` issued during busy → `stall`=1 and old LO shown; reset at iteration 10 → next cycle busy=0, hi=lo=0; a following `mthi` 0x1234 → hi=0x1234 after 1 edge.
